// File: rtl/wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched_pkg
// Description : Shared definitions for the writeback scheduler: functional
//               unit ids, per-unit latencies, the reservation-table entry
//               and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_sched_pkg;

  localparam int FU_W   = 3;
  localparam int RD_W   = 5;
  localparam int NUM_FU = 5;
  localparam int LAT_W  = 5;

  localparam logic [FU_W-1:0] FU_NONE = 3'd0;
  localparam logic [FU_W-1:0] FU_ALU  = 3'd1;
  localparam logic [FU_W-1:0] FU_MEM  = 3'd2;
  localparam logic [FU_W-1:0] FU_MUL  = 3'd3;
  localparam logic [FU_W-1:0] FU_DIV  = 3'd4;
  localparam logic [FU_W-1:0] FU_JUMP = 3'd5;

  localparam logic [LAT_W-1:0] LAT_ALU  = 5'd1;
  localparam logic [LAT_W-1:0] LAT_MEM  = 5'd2;
  localparam logic [LAT_W-1:0] LAT_MUL  = 5'd7;
  localparam logic [LAT_W-1:0] LAT_DIV  = 5'd24;
  localparam logic [LAT_W-1:0] LAT_JUMP = 5'd2;

  // One reservation-table slot; fu == FU_NONE marks an empty slot.
  typedef struct packed {
    logic [FU_W-1:0] fu;
    logic [RD_W-1:0] rd;
    logic            we;
  } entry_t;

  // Result latency of a unit; ids without a unit map to 1 and are never accepted.
  function automatic logic [LAT_W-1:0] fu_latency(input logic [FU_W-1:0] fu);
    logic [LAT_W-1:0] lat;
    case (fu)
      FU_ALU:  lat = LAT_ALU;
      FU_MEM:  lat = LAT_MEM;
      FU_MUL:  lat = LAT_MUL;
      FU_DIV:  lat = LAT_DIV;
      FU_JUMP: lat = LAT_JUMP;
      default: lat = LAT_ALU;
    endcase
    return lat;
  endfunction

  // Bit f-1 set for unit id f; all-zero for ids 0, 6 and 7.
  function automatic logic [NUM_FU-1:0] fu_onehot(input logic [FU_W-1:0] fu);
    logic [NUM_FU-1:0] oh;
    oh = '0;
    for (int f = 1; f <= NUM_FU; f++) begin
      if (fu == FU_W'(f)) oh[f-1] = 1'b1;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_resv_table.sv
`default_nettype none
// ============================================================================
// Module      : wb_resv_table
// Description : Reservation table. Shifts one slot toward slot 0 every cycle,
//               refills the top slot empty, and optionally writes one new
//               entry at a post-shift index. Exposes all slots plus an
//               occupancy read port at an arbitrary index.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_resv_table
  import wb_sched_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  entry_t                 i_wr_entry,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic                   o_rd_occupied,
  output entry_t [DEPTH-1:0]     o_slots
);

  entry_t [DEPTH-1:0] slots_q;
  entry_t [DEPTH-1:0] slots_d;

  // Shift toward slot 0, then overlay the newly accepted entry.
  always_comb begin
    slots_d = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      slots_d[i] = slots_q[i+1];
    end
    if (i_wr_en) slots_d[i_wr_idx] = i_wr_entry;
  end

  // Table storage; reset empties every slot so in-flight ops are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slots_q <= '0;
    else        slots_q <= slots_d;
  end

  assign o_rd_occupied = (slots_q[i_rd_idx].fu != FU_NONE);
  assign o_slots       = slots_q;

endmodule
`default_nettype wire

// File: rtl/wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wb_scheduler
// Description : Issue-time writeback scheduler. Tracks in-flight ops in a
//               shifting reservation table, blocks issue on structural,
//               writeback-port, RAW and WAW hazards, and emits a registered
//               writeback command when an entry leaves slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scheduler
  import wb_sched_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [2:0] issue_fu,
  input  logic [4:0] issue_rd,
  input  logic       issue_we,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       flush,
  output logic       issue_ready,
  output logic [4:0] fu_busy,
  output logic       wb_valid,
  output logic [2:0] wb_sel,
  output logic [4:0] wb_rd
);

  localparam int IDX_W = $clog2(DEPTH);

  entry_t [DEPTH-1:0] slots;
  entry_t             slot0;
  entry_t             new_entry;
  logic               lat_slot_busy;
  logic [LAT_W-1:0]   lat;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [NUM_FU-1:0]  issue_oh;
  logic [NUM_FU-1:0]  slot0_oh;
  logic               struct_hz;
  logic               raw_hz;
  logic               waw_hz;
  logic               accept;

  logic [NUM_FU-1:0]  fu_busy_q, fu_busy_d;
  logic               wb_valid_q, wb_valid_d;
  logic [FU_W-1:0]    wb_sel_q, wb_sel_d;
  logic [RD_W-1:0]    wb_rd_q, wb_rd_d;

  assign slot0 = slots[0];

  // Decode the issuing op: latency, table indices and the entry to insert.
  always_comb begin
    lat          = fu_latency(issue_fu);
    wr_idx       = IDX_W'(lat - LAT_W'(1));
    rd_idx       = IDX_W'(lat);
    issue_oh     = fu_onehot(issue_fu);
    slot0_oh     = fu_onehot(slot0.fu);
    new_entry.fu = issue_fu;
    new_entry.rd = issue_rd;
    new_entry.we = issue_we && (issue_rd != '0);
  end

  wb_resv_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (accept),
    .i_wr_idx      (wr_idx),
    .i_wr_entry    (new_entry),
    .i_rd_idx      (rd_idx),
    .o_rd_occupied (lat_slot_busy),
    .o_slots       (slots)
  );

  // Hazard detection; ready never looks at issue_valid or flush.
  // RAW scans slot 0 too: its result reaches the register file only on the
  // following cycle and there is no bypass, so a reader still has to wait.
  always_comb begin
    struct_hz = ((fu_busy_q & issue_oh) != '0) && (slot0.fu != issue_fu);
    raw_hz    = 1'b0;
    waw_hz    = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (slots[j].we && (slots[j].fu != FU_NONE)) begin
        if (rs1_used && (rs1 != '0) && (slots[j].rd == rs1)) raw_hz = 1'b1;
        if (rs2_used && (rs2 != '0) && (slots[j].rd == rs2)) raw_hz = 1'b1;
        if (issue_we && (issue_rd != '0) && (j > int'(lat)) &&
            (slots[j].rd == issue_rd)) waw_hz = 1'b1;
      end
    end
    issue_ready = (issue_oh != '0) && !struct_hz && !lat_slot_busy &&
                  !raw_hz && !waw_hz;
    accept      = issue_valid && issue_ready && !flush;
  end

  // Busy flags drop as a unit's entry leaves slot 0; a same-edge accept re-arms.
  always_comb begin
    fu_busy_d  = (fu_busy_q & ~slot0_oh) | (accept ? issue_oh : '0);
    wb_valid_d = slot0.we && (slot0.fu != FU_NONE);
    wb_sel_d   = slot0.fu;
    wb_rd_d    = slot0.rd;
  end

  // Busy flags and the registered writeback command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_busy_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_rd_q    <= '0;
    end else begin
      fu_busy_q  <= fu_busy_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign fu_busy  = fu_busy_q;
  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_rd    = wb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_scheduler
// Description : Directed self-checking bench for wb_scheduler. Cycle c of a
//               scenario starts at the c-th rising edge after reset release;
//               inputs change 1 ns after that edge, outputs are read on the
//               falling edge of the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       issue_valid, issue_we, rs1_used, rs2_used, flush;
  logic [2:0] issue_fu;
  logic [4:0] issue_rd, rs1, rs2;
  logic       issue_ready, wb_valid;
  logic [4:0] fu_busy, wb_rd;
  logic [2:0] wb_sel;

  int checks = 0;
  int errors = 0;

  wb_scheduler #(.DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_rd(issue_rd), .issue_we(issue_we), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .issue_ready(issue_ready), .fu_busy(fu_busy), .wb_valid(wb_valid),
    .wb_sel(wb_sel), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    issue_valid = 0; issue_fu = 0; issue_rd = 0; issue_we = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; flush = 0;
  endtask

  task automatic drive_issue(input logic [2:0] fu, input logic [4:0] rd,
                             input logic [4:0] r1, input logic r1u);
    issue_valid = 1; issue_fu = fu; issue_rd = rd; issue_we = 1;
    rs1 = r1; rs1_used = r1u;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 0;
    #10;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (wb_sel !== 3'd0) begin errors++; $display("FAIL reset_wb_sel got %0d exp 0", wb_sel); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d exp 0", wb_rd); end
    checks++; if (fu_busy !== 5'd0) begin errors++; $display("FAIL reset_fu_busy got %b exp 00000", fu_busy); end
    @(negedge clk) rst_n = 1;
    for (int c = 0; c <= 2; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd1, 5'd5, 5'd0, 1'b0);
      if (c == 2) begin
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_wb got %b exp 1", wb_valid); end
        rst_n = 0;
        #1;
        checks++; if (wb_valid !== 1'b0 || wb_sel !== 3'd0 || wb_rd !== 5'd0)
          begin errors++; $display("FAIL reset_async_clear got v=%b sel=%0d rd=%0d exp 0/0/0", wb_valid, wb_sel, wb_rd); end
      end else begin
        @(negedge clk);
        if (c == 0) begin
          checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_resume_ready got %b exp 1", issue_ready); end
        end
      end
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_alu();
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd1, 5'd5, 5'd0, 1'b0);
      @(negedge clk);
      if (c == 0) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", issue_ready); end
      end
      if (c == 1) begin
        checks++; if (fu_busy !== 5'b00001) begin errors++; $display("FAIL alu_busy_set got %b exp 00001", fu_busy); end
      end
      if (c == 2) begin
        checks++; if (fu_busy !== 5'b00000) begin errors++; $display("FAIL alu_busy_clr got %b exp 00000", fu_busy); end
      end
      exp_v = (c == 2);
      checks++; if (wb_valid !== exp_v) begin errors++; $display("FAIL alu_wb_valid c=%0d got %b exp %b", c, wb_valid, exp_v); end
      if (exp_v) begin
        checks++; if (wb_sel !== 3'd1 || wb_rd !== 5'd5)
          begin errors++; $display("FAIL alu_wb_cmd got sel=%0d rd=%0d exp 1/5", wb_sel, wb_rd); end
      end
    end
  endtask

  task automatic test_raw();
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd3, 5'd3, 5'd0, 1'b0);
      if (c >= 1 && c <= 8) drive_issue(3'd1, 5'd9, 5'd3, 1'b1);
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        checks++; if (issue_ready !== (c >= 8)) begin errors++; $display("FAIL raw_ready c=%0d got %b exp %b", c, issue_ready, (c >= 8)); end
      end
      exp_v = (c == 8 || c == 10);
      checks++; if (wb_valid !== exp_v) begin errors++; $display("FAIL raw_wb_valid c=%0d got %b exp %b", c, wb_valid, exp_v); end
      if (c == 8) begin
        checks++; if (wb_sel !== 3'd3 || wb_rd !== 5'd3) begin errors++; $display("FAIL raw_wb_mul got sel=%0d rd=%0d exp 3/3", wb_sel, wb_rd); end
      end
      if (c == 10) begin
        checks++; if (wb_sel !== 3'd1 || wb_rd !== 5'd9) begin errors++; $display("FAIL raw_wb_alu got sel=%0d rd=%0d exp 1/9", wb_sel, wb_rd); end
      end
    end
  endtask

  task automatic test_waw();
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd4, 5'd7, 5'd0, 1'b0);
      if (c >= 1 && c <= 24) drive_issue(3'd1, 5'd7, 5'd0, 1'b0);
      @(negedge clk);
      if (c == 1) begin
        checks++; if (fu_busy !== 5'b01000) begin errors++; $display("FAIL waw_div_busy got %b exp 01000", fu_busy); end
      end
      if (c >= 1 && c <= 24) begin
        checks++; if (issue_ready !== (c >= 24)) begin errors++; $display("FAIL waw_ready c=%0d got %b exp %b", c, issue_ready, (c >= 24)); end
      end
      exp_v = (c == 25 || c == 26);
      checks++; if (wb_valid !== exp_v) begin errors++; $display("FAIL waw_wb_valid c=%0d got %b exp %b", c, wb_valid, exp_v); end
      if (c == 25) begin
        checks++; if (wb_sel !== 3'd4 || wb_rd !== 5'd7) begin errors++; $display("FAIL waw_wb_div got sel=%0d rd=%0d exp 4/7", wb_sel, wb_rd); end
      end
      if (c == 26) begin
        checks++; if (wb_sel !== 3'd1 || wb_rd !== 5'd7) begin errors++; $display("FAIL waw_wb_alu got sel=%0d rd=%0d exp 1/7", wb_sel, wb_rd); end
      end
    end
  endtask

  // second_fu/second_rd follow MEM one cycle later; expected ready per cycle given.
  task automatic test_wb_port(input logic [2:0] second_fu, input logic [4:0] second_rd,
                              input logic exp_rdy1, input logic [2:0] exp_sel4);
    logic accepted;
    do_reset();
    accepted = 0;
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd2, 5'd4, 5'd0, 1'b0);
      if ((c == 1 || c == 2) && !accepted) drive_issue(second_fu, second_rd, 5'd0, 1'b0);
      @(negedge clk);
      if (c == 1) begin
        checks++; if (issue_ready !== exp_rdy1) begin errors++; $display("FAIL wbport_ready1 fu=%0d got %b exp %b", second_fu, issue_ready, exp_rdy1); end
        accepted = exp_rdy1;
      end
      if (c == 2 && !exp_rdy1) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL wbport_ready2 fu=%0d got %b exp 1", second_fu, issue_ready); end
      end
      if (c == 3) begin
        checks++; if (wb_valid !== 1'b1 || wb_sel !== 3'd2 || wb_rd !== 5'd4)
          begin errors++; $display("FAIL wbport_wb_mem got v=%b sel=%0d rd=%0d exp 1/2/4", wb_valid, wb_sel, wb_rd); end
      end
      if (c == 4) begin
        checks++; if (wb_valid !== 1'b1 || wb_sel !== exp_sel4 || wb_rd !== second_rd)
          begin errors++; $display("FAIL wbport_wb_second got v=%b sel=%0d rd=%0d exp 1/%0d/%0d", wb_valid, wb_sel, wb_rd, exp_sel4, second_rd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd3, 5'd10, 5'd0, 1'b0);
      if (c >= 1 && c <= 7) drive_issue(3'd3, 5'd11, 5'd0, 1'b0);
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        checks++; if (issue_ready !== (c >= 7)) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, issue_ready, (c >= 7)); end
      end
      if (c >= 1 && c <= 8) begin
        checks++; if (fu_busy[2] !== 1'b1) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp 1", c, fu_busy[2]); end
      end
      if (c == 15) begin
        checks++; if (fu_busy[2] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", fu_busy[2]); end
      end
      exp_v = (c == 8 || c == 15);
      checks++; if (wb_valid !== exp_v) begin errors++; $display("FAIL b2b_wb_valid c=%0d got %b exp %b", c, wb_valid, exp_v); end
      if (exp_v) begin
        checks++; if (wb_sel !== 3'd3 || wb_rd !== ((c == 8) ? 5'd10 : 5'd11))
          begin errors++; $display("FAIL b2b_wb_cmd c=%0d got sel=%0d rd=%0d", c, wb_sel, wb_rd); end
      end
    end
  endtask

  task automatic test_flush_misc();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) begin drive_issue(3'd1, 5'd5, 5'd0, 1'b0); flush = 1; end
      if (c == 3) issue_fu = 3'd6;
      if (c == 4) drive_issue(3'd1, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      if (c == 0) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_indep got %b exp 1", issue_ready); end
      end
      if (c == 1) begin
        checks++; if (fu_busy !== 5'd0) begin errors++; $display("FAIL flush_busy got %b exp 00000", fu_busy); end
      end
      if (c == 2) begin
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wb got %b exp 0", wb_valid); end
      end
      if (c == 3) begin
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bad_fu6_ready got %b exp 0", issue_ready); end
        issue_fu = 3'd0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bad_fu0_ready got %b exp 0", issue_ready); end
      end
      if (c == 4) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b exp 1", issue_ready); end
      end
      if (c == 6) begin
        checks++; if (wb_valid !== 1'b0 || wb_sel !== 3'd1 || wb_rd !== 5'd0)
          begin errors++; $display("FAIL rd0_wb got v=%b sel=%0d rd=%0d exp 0/1/0", wb_valid, wb_sel, wb_rd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) drive_issue(3'd4, 5'd7, 5'd0, 1'b0);
    end
    checks++; if (fu_busy !== 5'b01000) begin errors++; $display("FAIL midrst_pre_busy got %b exp 01000", fu_busy); end
    rst_n = 0;
    #1;
    checks++; if (fu_busy !== 5'd0 || wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_clear got busy=%b v=%b exp 0/0", fu_busy, wb_valid); end
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_wb c=%0d got %b exp 0", c, wb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_raw();
    test_waw();
    test_wb_port(3'd5, 5'd6, 1'b1, 3'd5);
    test_wb_port(3'd1, 5'd8, 1'b0, 3'd1);
    test_back_to_back();
    test_flush_misc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
